parking_exit_controller: RTL and testbench

Exit-side counterpart to the parking entry controller. It handles a car arriving at the exit barrier and checks a two-part exit token. On a valid token it opens the gate. It decrements the shared occupancy count once the car has cleared the barrier. It also owns the occupancy counter, which the entry side increments through the car_entered pulse, and drives the exit lights and a 7-segment occupancy display.

---
 rtl/parking_exit_if.sv | 34 +++
 rtl/parking_exit_controller.sv | 182 ++++++++++++++++++
 tb/tb_parking_exit_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_exit_if.sv
// Exit-barrier bus: sensors, token and entry pulse in,
// gate, lights, occupancy and display out.
interface parking_exit_if;
  logic       sense_exit;
  logic       sense_clear;
  logic [1:0] token_1;
  logic [1:0] token_2;
  logic       car_entered;
  logic       gate_open;
  logic       green_light;
  logic       red_light;
  logic       alarm;
  logic [3:0] cars_inside;
  logic [7:0] exits_total;
  logic [6:0] hex_count;

  modport master (
    output sense_exit, sense_clear,
    output token_1, token_2, car_entered,
    input  gate_open, green_light,
    input  red_light, alarm,
    input  cars_inside, exits_total,
    input  hex_count
  );

  modport slave (
    input  sense_exit, sense_clear,
    input  token_1, token_2, car_entered,
    output gate_open, green_light,
    output red_light, alarm,
    output cars_inside, exits_total,
    output hex_count
  );
endinterface

// File: rtl/parking_exit_controller.sv
// Exit barrier controller: token check, gate control,
// shared occupancy counter and 7-segment display.
module parking_exit_controller #(
  parameter int         CAPACITY      = 8,
  parameter logic [1:0] EXIT_KEY_1    = 2'b10,
  parameter logic [1:0] EXIT_KEY_2    = 2'b01,
  parameter int         TOKEN_TIMEOUT = 4,
  parameter int         OPEN_TIMEOUT  = 8,
  parameter int         DENY_HOLD     = 2,
  parameter int         MAX_FAILS     = 3
) (
  input logic           clk,
  input logic           rst,
  parking_exit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_OPEN,
    S_DENY,
    S_LOCKED
  } state_t;

  localparam logic [7:0] TOK_LAST  = 8'(TOKEN_TIMEOUT - 1);
  localparam logic [7:0] OPEN_LAST = 8'(OPEN_TIMEOUT - 1);
  localparam logic [7:0] DENY_LAST = 8'(DENY_HOLD - 1);
  localparam logic [3:0] FAIL_MAX  = 4'(MAX_FAILS);
  localparam logic [3:0] CAP       = 4'(CAPACITY);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_timer;
  logic [7:0] w_timer;
  logic [3:0] r_fails;
  logic [3:0] w_fails;
  logic [3:0] r_cars;
  logic [3:0] w_cars;
  logic [7:0] r_exits;
  logic [7:0] w_exits;
  logic [6:0] r_hex;
  logic       r_gate;
  logic       r_green;
  logic       r_red;
  logic       r_alarm;
  logic       w_match;
  logic       w_dec;

  function automatic logic [6:0] seg7(
    input logic [3:0] v
  );
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_match = (bus.token_1 == EXIT_KEY_1)
                && (bus.token_2 == EXIT_KEY_2);

  // Next state, phase timer, fail count and exit event.
  always_comb begin
    w_next  = r_state;
    w_timer = r_timer;
    w_fails = r_fails;
    w_dec   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer = '0;
        if (bus.sense_exit)
          w_next = (r_cars != '0) ? S_CHECK : S_DENY;
      end
      S_CHECK: begin
        if (!bus.sense_exit) begin
          w_next = S_IDLE;
        end else if (w_match) begin
          w_next  = S_OPEN;
          w_timer = '0;
        end else if (r_timer == TOK_LAST) begin
          w_next  = S_DENY;
          w_timer = '0;
          w_fails = r_fails + 4'd1;
        end else begin
          w_timer = r_timer + 8'd1;
        end
      end
      S_OPEN: begin
        if (bus.sense_clear) begin
          w_next  = S_IDLE;
          w_dec   = 1'b1;
          w_fails = '0;
        end else if (r_timer == OPEN_LAST) begin
          w_next = S_IDLE;
        end else begin
          w_timer = r_timer + 8'd1;
        end
      end
      S_DENY: begin
        if (r_timer == DENY_LAST) begin
          w_timer = '0;
          if (r_fails == FAIL_MAX)
            w_next = S_LOCKED;
          else if (bus.sense_exit)
            w_next = S_CHECK;
          else
            w_next = S_IDLE;
        end else begin
          w_timer = r_timer + 8'd1;
        end
      end
      S_LOCKED: begin
        w_next = S_LOCKED;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Occupancy: entry and exit in one cycle cancel out.
  always_comb begin
    w_cars  = r_cars;
    w_exits = r_exits;
    if (bus.car_entered && !w_dec) begin
      if (r_cars < CAP)
        w_cars = r_cars + 4'd1;
    end else if (w_dec && !bus.car_entered) begin
      if (r_cars != '0)
        w_cars = r_cars - 4'd1;
    end
    if (w_dec && (r_exits != 8'hFF))
      w_exits = r_exits + 8'd1;
  end

  // State, counters and Moore outputs from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_fails <= '0;
      r_cars  <= '0;
      r_exits <= '0;
      r_hex   <= 7'b1000000;
      r_gate  <= 1'b0;
      r_green <= 1'b0;
      r_red   <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer;
      r_fails <= w_fails;
      r_cars  <= w_cars;
      r_exits <= w_exits;
      r_hex   <= seg7(r_cars);
      r_gate  <= (w_next == S_OPEN);
      r_green <= (w_next == S_OPEN);
      r_red   <= (w_next == S_DENY)
              || (w_next == S_LOCKED);
      r_alarm <= (w_next == S_LOCKED);
    end
  end

  assign bus.gate_open   = r_gate;
  assign bus.green_light = r_green;
  assign bus.red_light   = r_red;
  assign bus.alarm       = r_alarm;
  assign bus.cars_inside = r_cars;
  assign bus.exits_total = r_exits;
  assign bus.hex_count   = r_hex;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Bench: directed scenarios plus random traffic,
// checked against a phase/age reference model.
module tb_parking_exit_controller;

  localparam int CAPACITY      = 8;
  localparam int TOKEN_TIMEOUT = 4;
  localparam int OPEN_TIMEOUT  = 8;
  localparam int DENY_HOLD     = 2;
  localparam int MAX_FAILS     = 3;
  localparam int P_IDLE = 0;
  localparam int P_CHK  = 1;
  localparam int P_OPEN = 2;
  localparam int P_DENY = 3;
  localparam int P_LOCK = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  int         m_ph;
  int         m_age;
  int         m_fails;
  int         m_cars;
  int         m_exits;
  logic [6:0] m_hex;
  logic [6:0] seg_tab [10];

  parking_exit_if ifc ();

  parking_exit_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic model(
    input bit       r,
    input bit       se,
    input bit       sc,
    input bit [1:0] t1,
    input bit [1:0] t2,
    input bit       ce
  );
    int nph;
    int old_cars;
    bit dec;
    if (r) begin
      m_ph    = P_IDLE;
      m_age   = 0;
      m_fails = 0;
      m_cars  = 0;
      m_exits = 0;
      m_hex   = seg_tab[0];
      return;
    end
    old_cars = m_cars;
    dec      = 1'b0;
    nph      = m_ph;
    case (m_ph)
      P_IDLE:
        if (se) nph = (m_cars > 0) ? P_CHK : P_DENY;
      P_CHK:
        if (!se) nph = P_IDLE;
        else if (t1 == 2'b10 && t2 == 2'b01)
          nph = P_OPEN;
        else if (m_age + 1 >= TOKEN_TIMEOUT) begin
          nph = P_DENY;
          m_fails++;
        end
      P_OPEN:
        if (sc) begin
          dec     = 1'b1;
          m_fails = 0;
          nph     = P_IDLE;
          if (m_exits < 255) m_exits++;
        end else if (m_age + 1 >= OPEN_TIMEOUT)
          nph = P_IDLE;
      P_DENY:
        if (m_age + 1 >= DENY_HOLD) begin
          if (m_fails >= MAX_FAILS) nph = P_LOCK;
          else if (se) nph = P_CHK;
          else nph = P_IDLE;
        end
      default: nph = P_LOCK;
    endcase
    m_age = (nph == m_ph) ? m_age + 1 : 0;
    m_ph  = nph;
    if (ce && !dec) begin
      if (m_cars < CAPACITY) m_cars++;
    end else if (dec && !ce && m_cars > 0) begin
      m_cars--;
    end
    m_hex = seg_tab[old_cars];
  endtask

  task automatic tick(
    input bit       r,
    input bit       se,
    input bit       sc,
    input bit [1:0] t1,
    input bit [1:0] t2,
    input bit       ce
  );
    rst             = r;
    ifc.sense_exit  = se;
    ifc.sense_clear = sc;
    ifc.token_1     = t1;
    ifc.token_2     = t2;
    ifc.car_entered = ce;
    @(posedge clk);
    model(r, se, sc, t1, t2, ce);
    @(negedge clk);
    chk("gate", int'(ifc.gate_open),
        int'(m_ph == P_OPEN));
    chk("green", int'(ifc.green_light),
        int'(m_ph == P_OPEN));
    chk("red", int'(ifc.red_light),
        int'(m_ph == P_DENY || m_ph == P_LOCK));
    chk("alarm", int'(ifc.alarm),
        int'(m_ph == P_LOCK));
    chk("cars", int'(ifc.cars_inside), m_cars);
    chk("exits", int'(ifc.exits_total), m_exits);
    chk("hex", int'(ifc.hex_count), int'(m_hex));
  endtask

  task automatic idle();
    tick(0, 0, 0, 2'b00, 2'b00, 0);
  endtask

  task automatic reset();
    tick(1, 0, 0, 2'b00, 2'b00, 0);
  endtask

  initial begin
    bit       r;
    bit       se;
    bit       sc;
    bit       ce;
    bit [1:0] t1;
    bit [1:0] t2;
    n_tests = 0;
    n_fail  = 0;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100,
                7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000,
                7'b0010000};

    // valid exit
    reset();
    chk("rst_hex", int'(ifc.hex_count), 7'b1000000);
    chk("rst_cars", int'(ifc.cars_inside), 0);
    repeat (3) tick(0, 0, 0, 2'b00, 2'b00, 1);
    tick(0, 1, 0, 2'b10, 2'b01, 0);
    chk("t1_gate_early", int'(ifc.gate_open), 0);
    tick(0, 1, 0, 2'b10, 2'b01, 0);
    chk("t1_gate", int'(ifc.gate_open), 1);
    chk("t1_green", int'(ifc.green_light), 1);
    tick(0, 0, 1, 2'b00, 2'b00, 0);
    chk("t1_cars", int'(ifc.cars_inside), 2);
    chk("t1_exits", int'(ifc.exits_total), 1);
    idle();
    chk("t1_hex", int'(ifc.hex_count), 7'b0100100);

    // wrong token until lockout
    reset();
    tick(0, 0, 0, 2'b00, 2'b00, 1);
    for (int i = 0; i < 19; i++) begin
      tick(0, 1, 0, 2'b00, 2'b00, 0);
      if (i == 3)
        chk("t2_red_pre", int'(ifc.red_light), 0);
      if (i == 4)
        chk("t2_red", int'(ifc.red_light), 1);
    end
    chk("t2_alarm", int'(ifc.alarm), 1);
    repeat (3) tick(0, 1, 1, 2'b10, 2'b01, 0);
    chk("t2_locked", int'(ifc.gate_open), 0);
    reset();
    chk("t2_rst_red", int'(ifc.red_light), 0);
    chk("t2_rst_alarm", int'(ifc.alarm), 0);
    chk("t2_rst_hex", int'(ifc.hex_count), 7'b1000000);

    // phantom exits never count as failures
    reset();
    repeat (3) begin
      tick(0, 1, 0, 2'b10, 2'b01, 0);
      chk("t3_red", int'(ifc.red_light), 1);
      idle();
      idle();
    end
    chk("t3_red_off", int'(ifc.red_light), 0);
    chk("t3_alarm", int'(ifc.alarm), 0);

    // saturation and collision
    reset();
    repeat (10) tick(0, 0, 0, 2'b00, 2'b00, 1);
    chk("t4_sat", int'(ifc.cars_inside), 8);
    tick(0, 1, 0, 2'b10, 2'b01, 0);
    tick(0, 1, 0, 2'b10, 2'b01, 0);
    tick(0, 0, 1, 2'b00, 2'b00, 1);
    chk("t4_coll", int'(ifc.cars_inside), 8);
    chk("t4_exits", int'(ifc.exits_total), 1);

    // open timeout and backoff
    reset();
    tick(0, 0, 0, 2'b00, 2'b00, 1);
    tick(0, 1, 0, 2'b10, 2'b01, 0);
    tick(0, 1, 0, 2'b10, 2'b01, 0);
    repeat (7) idle();
    chk("t5_still_open", int'(ifc.gate_open), 1);
    idle();
    chk("t5_closed", int'(ifc.gate_open), 0);
    chk("t5_cars", int'(ifc.cars_inside), 1);
    tick(0, 1, 0, 2'b00, 2'b00, 0);
    idle();
    chk("t5_backoff", int'(ifc.red_light), 0);

    // reset while open
    reset();
    tick(0, 0, 0, 2'b00, 2'b00, 1);
    tick(0, 1, 0, 2'b10, 2'b01, 0);
    tick(0, 1, 0, 2'b10, 2'b01, 0);
    chk("t6_open", int'(ifc.gate_open), 1);
    tick(1, 1, 0, 2'b10, 2'b01, 0);
    chk("t6_gate", int'(ifc.gate_open), 0);
    chk("t6_cars", int'(ifc.cars_inside), 0);

    // random traffic
    reset();
    se = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) se = ~se;
      sc = ($urandom_range(0, 5) == 0);
      ce = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        t1 = 2'b10;
        t2 = 2'b01;
      end else begin
        t1 = 2'($urandom_range(0, 3));
        t2 = 2'($urandom_range(0, 3));
      end
      tick(r, se, sc, t1, t2, ce);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
